// File: rtl/laser_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : laser_link_pkg
// Description : Shared types and constants for the laser link transmit and
//               receive controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package laser_link_pkg;

  // Transmit sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL_REQ  = 3'd1,
    ST_FILL_CAP  = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_WAIT_ACK  = 3'd5,
    ST_REPORT    = 3'd6
  } state_t;

  localparam logic [7:0] START_BYTE = 8'h7E;
  localparam logic [7:0] ACK_BASE   = 8'hA0;
  localparam int         TIMER_W    = 24;

  // A frame is start + seq + payload + checksum, indices 0..pkt_len+2
  function automatic int frame_idx_width(input int pkt_len);
    return $clog2(pkt_len + 3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ack_timer.sv
`default_nettype none
// ============================================================================
// Module      : ack_timer
// Description : Loadable up-counter with synchronous clear, count enable and
//               a terminal-count flag raised while the count equals TC_VALUE.
// Revision    : 1.0 - initial release
// ============================================================================
module ack_timer
  import laser_link_pkg::*;
#(
  parameter logic [TIMER_W-1:0] TC_VALUE = '1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_value,
  input  logic               i_enable,
  output logic               o_tc
);

  logic [TIMER_W-1:0] r_count;

  // Counter: clear beats load, load beats count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign o_tc = (r_count == TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/laser_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : laser_tx_sequencer
// Description : Packet transmit controller. Pulls PKT_LEN payload bytes from
//               the FTDI read queue, frames them as start/seq/payload/chk,
//               feeds the transmitter byte by byte and retransmits the whole
//               frame until the matching ACK arrives or retries run out.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_tx_sequencer #(
  parameter int         PKT_LEN    = 4,
  parameter int         TIMEOUT    = 50000,
  parameter int         MAX_RETRY  = 3,
  parameter logic [7:0] START_BYTE = laser_link_pkg::START_BYTE,
  parameter logic [7:0] ACK_BASE   = laser_link_pkg::ACK_BASE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       rdq_empty,
  input  logic [7:0] data_rd,
  output logic       rdreq,
  input  logic       tx_done,
  output logic       data_ready,
  output logic [7:0] data_transmit,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       pkt_sent,
  output logic       pkt_failed,
  output logic [1:0] retry_count
);

  import laser_link_pkg::*;

  localparam int                 c_idx_w      = frame_idx_width(PKT_LEN);
  localparam int                 c_buf_w      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [c_idx_w-1:0] c_idx_one    = c_idx_w'(1);
  localparam logic [c_idx_w-1:0] c_last_fill  = c_idx_w'(PKT_LEN - 1);
  localparam logic [c_idx_w-1:0] c_last_frame = c_idx_w'(PKT_LEN + 2);
  localparam logic [1:0]         c_max_retry  = 2'(MAX_RETRY);
  localparam logic [TIMER_W-1:0] c_timer_tc   = TIMER_W'(TIMEOUT - 1);

  if ((PKT_LEN < 1) || (PKT_LEN > 16)) begin : g_bad_pkt_len
    $error("laser_tx_sequencer: PKT_LEN must be in 1..16");
  end
  if ((MAX_RETRY < 0) || (MAX_RETRY > 3)) begin : g_bad_max_retry
    $error("laser_tx_sequencer: MAX_RETRY must be in 0..3");
  end
  if ((TIMEOUT < 1) || (TIMEOUT >= (1 << TIMER_W))) begin : g_bad_timeout
    $error("laser_tx_sequencer: TIMEOUT must be in 1..2^24-1");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_seq;
  logic [1:0]           r_retry;
  logic [7:0]           r_chk;
  logic                 r_success;
  logic [7:0]           r_data_transmit;
  logic [7:0]           r_buf [PKT_LEN];

  logic                 w_ack_hit;
  logic                 w_timer_clear;
  logic                 w_timer_tc;
  logic [c_idx_w-1:0]   w_idx_next;
  logic [c_buf_w-1:0]   w_fill_ptr;
  logic [c_buf_w-1:0]   w_payload_ptr;
  logic [7:0]           w_frame_byte;

  assign w_ack_hit     = data_valid && (data_in == (ACK_BASE | {7'b0, r_seq}));
  assign w_fill_ptr    = c_buf_w'(r_idx);
  assign data_transmit = r_data_transmit;
  assign retry_count   = r_retry;

  // ACK wait timer, restarted each time the last frame byte completes
  ack_timer #(
    .TC_VALUE (c_timer_tc)
  ) u_ack_timer (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (w_timer_clear),
    .i_load       (1'b0),
    .i_load_value ('0),
    .i_enable     (r_state == ST_WAIT_ACK),
    .o_tc         (w_timer_tc)
  );

  // Frame byte that follows the current index (seq, payload or checksum)
  always_comb begin
    w_idx_next    = r_idx + c_idx_one;
    w_payload_ptr = c_buf_w'(r_idx - c_idx_one);
    w_frame_byte  = r_buf[w_payload_ptr];
    if (w_idx_next == c_idx_one) begin
      w_frame_byte = {7'b0, r_seq};
    end else if (w_idx_next == c_last_frame) begin
      w_frame_byte = r_chk;
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake strobes
  always_comb begin
    w_state_nxt   = r_state;
    rdreq         = 1'b0;
    data_ready    = 1'b0;
    pkt_sent      = 1'b0;
    pkt_failed    = 1'b0;
    w_timer_clear = 1'b0;
    busy          = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (en && !rdq_empty) begin
          w_state_nxt = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: begin
        // A partially filled packet waits here indefinitely for more bytes
        if (!rdq_empty) begin
          rdreq       = 1'b1;
          w_state_nxt = ST_FILL_CAP;
        end
      end
      ST_FILL_CAP: begin
        w_state_nxt = (r_idx == c_last_fill) ? ST_SEND : ST_FILL_REQ;
      end
      ST_SEND: begin
        data_ready  = 1'b1;
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (r_idx == c_last_frame) begin
            w_timer_clear = 1'b1;
            w_state_nxt   = ST_WAIT_ACK;
          end else begin
            w_state_nxt = ST_SEND;
          end
        end
      end
      ST_WAIT_ACK: begin
        // A matching ACK takes priority over a timeout in the same cycle
        if (w_ack_hit) begin
          w_state_nxt = ST_REPORT;
        end else if (w_timer_tc) begin
          w_state_nxt = (r_retry < c_max_retry) ? ST_SEND : ST_REPORT;
        end
      end
      ST_REPORT: begin
        pkt_sent    = r_success;
        pkt_failed  = !r_success;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: fill buffer, running checksum, byte index, seq and retries
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx           <= '0;
      r_seq           <= 1'b0;
      r_retry         <= '0;
      r_chk           <= '0;
      r_success       <= 1'b0;
      r_data_transmit <= '0;
      for (int i = 0; i < PKT_LEN; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_state_nxt == ST_FILL_REQ) begin
            r_idx <= '0;
            r_chk <= {7'b0, r_seq};
          end
        end
        ST_FILL_CAP: begin
          r_buf[w_fill_ptr] <= data_rd;
          r_chk             <= r_chk ^ data_rd;
          if (r_idx == c_last_fill) begin
            r_idx           <= '0;
            r_data_transmit <= START_BYTE;
          end else begin
            r_idx <= r_idx + c_idx_one;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done) begin
            if (r_idx == c_last_frame) begin
              r_idx <= '0;
            end else begin
              r_idx           <= w_idx_next;
              r_data_transmit <= w_frame_byte;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (w_ack_hit) begin
            r_success <= 1'b1;
          end else if (w_timer_tc) begin
            if (r_retry < c_max_retry) begin
              // Resend the whole frame from the retained buffer, same seq
              r_retry         <= r_retry + 2'd1;
              r_idx           <= '0;
              r_data_transmit <= START_BYTE;
            end else begin
              r_success <= 1'b0;
            end
          end
        end
        ST_REPORT: begin
          if (r_success) begin
            r_seq <= ~r_seq;
          end
          r_retry   <= '0;
          r_success <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_laser_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_tx_sequencer
// Description : Directed self-checking bench for laser_tx_sequencer with an
//               FTDI queue model, a transmitter model and a pulse monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_tx_sequencer;

  localparam int TIMEOUT = 150;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic       rdq_empty;
  logic [7:0] data_rd = 8'h00;
  logic       rdreq;
  logic       tx_done = 1'b0;
  logic       data_ready;
  logic [7:0] data_transmit;
  logic       data_valid;
  logic [7:0] data_in;
  logic       busy;
  logic       pkt_sent;
  logic       pkt_failed;
  logic [1:0] retry_count;

  int vectors     = 0;
  int miscompares = 0;

  // FTDI read queue model
  logic [7:0] fifo_mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  // Transmitter model and monitor state
  int         tx_cnt = 0;
  logic [7:0] cap [0:127];
  logic [1:0] cap_retry [0:127];
  int         cap_n = 0;
  int         done_n = 0;
  int         sent_n = 0;
  int         fail_n = 0;
  int         cyc = 0;
  int         last_done_cyc = 0;
  int         fail_cyc = 0;

  laser_tx_sequencer #(
    .PKT_LEN    (4),
    .TIMEOUT    (TIMEOUT),
    .MAX_RETRY  (3),
    .START_BYTE (8'h7E),
    .ACK_BASE   (8'hA0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .en            (en),
    .rdq_empty     (rdq_empty),
    .data_rd       (data_rd),
    .rdreq         (rdreq),
    .tx_done       (tx_done),
    .data_ready    (data_ready),
    .data_transmit (data_transmit),
    .data_valid    (data_valid),
    .data_in       (data_in),
    .busy          (busy),
    .pkt_sent      (pkt_sent),
    .pkt_failed    (pkt_failed),
    .retry_count   (retry_count)
  );

  always #5 clock = ~clock;

  assign rdq_empty = (wr_ptr == rd_ptr);

  // Queue pop: data appears the cycle after rdreq
  always @(posedge clock) begin
    if (rdreq) begin
      data_rd <= fifo_mem[rd_ptr[5:0]];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  // Transmitter: tx_done pulse a few cycles after each data_ready
  always @(posedge clock) begin
    tx_done <= 1'b0;
    if (data_ready) begin
      tx_cnt <= 3;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_done <= 1'b1;
    end
  end

  // Monitor: capture transmitted bytes and count pulses
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (data_ready) begin
      cap[cap_n[6:0]]       <= data_transmit;
      cap_retry[cap_n[6:0]] <= retry_count;
      cap_n                 <= cap_n + 1;
    end
    if (tx_done) begin
      done_n        <= done_n + 1;
      last_done_cyc <= cyc;
    end
    if (pkt_sent) sent_n <= sent_n + 1;
    if (pkt_failed) begin
      fail_n   <= fail_n + 1;
      fail_cyc <= cyc;
    end
  end

  function automatic logic [55:0] frame_at(input int b);
    logic [55:0] f;
    f = '0;
    for (int i = 0; i < 7; i++) f = {f[47:0], cap[(b + i) % 128]};
    return f;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    data_valid = 1'b1;
    data_in    = b;
    @(negedge clock);
    data_valid = 1'b0;
    data_in    = 8'h00;
  endtask

  task automatic wait_done_count(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (done_n < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    ok = (done_n >= target);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    vectors++;
    if ({busy, data_ready, rdreq, pkt_sent, pkt_failed, retry_count, data_transmit} !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, want 0",
               {busy, data_ready, rdreq, pkt_sent, pkt_failed, retry_count, data_transmit});
    end
    reset = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (10) @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || cap_n != 0 || rdreq !== 1'b0) begin
      miscompares++;
      $display("FAIL en_low_hold: busy=%b cap_n=%0d rdreq=%b, want 0/0/0", busy, cap_n, rdreq);
    end
  endtask

  task automatic test_single_packet;
    int b, s, f;
    bit ok;
    b = cap_n; s = sent_n; f = fail_n;
    en = 1'b1;
    wait_done_count(done_n + 7, 400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL single_frame_timeout: done_n=%0d, want %0d", done_n, b + 7); end
    repeat (99) @(negedge clock);
    vectors++;
    if (sent_n != s) begin miscompares++; $display("FAIL single_early_sent: got %0d, want %0d", sent_n, s); end
    rx_byte(8'hA0);
    repeat (5) @(negedge clock);
    vectors++;
    if (frame_at(b) !== 56'h7E_00_11_22_33_44_44) begin
      miscompares++; $display("FAIL single_frame: got %h, want 7e00112233444 4", frame_at(b));
    end
    vectors++;
    if (sent_n != s + 1 || fail_n != f) begin
      miscompares++; $display("FAIL single_pulses: sent=%0d fail=%0d, want %0d %0d", sent_n, fail_n, s + 1, f);
    end
    vectors++;
    if (retry_count !== 2'd0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL single_idle: retry=%0d busy=%b, want 0 0", retry_count, busy);
    end
  endtask

  task automatic test_ack_on_timeout;
    int b, s;
    bit ok;
    b = cap_n; s = sent_n;
    push(8'h01); push(8'h02); push(8'h04); push(8'h08);
    wait_done_count(done_n + 7, 400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL tmo_frame_timeout: done_n=%0d", done_n); end
    repeat (TIMEOUT - 1) @(negedge clock);
    rx_byte(8'hA1);
    repeat (20) @(negedge clock);
    vectors++;
    if (frame_at(b) !== 56'h7E_01_01_02_04_08_0E) begin
      miscompares++; $display("FAIL tmo_frame: got %h, want 7e01010204080e", frame_at(b));
    end
    vectors++;
    if (sent_n != s + 1 || cap_n != b + 7) begin
      miscompares++; $display("FAIL tmo_ack_wins: sent=%0d bytes=%0d, want %0d %0d", sent_n, cap_n - b, s + 1, 7);
    end
  endtask

  task automatic test_back_to_back;
    int b, d, s;
    bit ok;
    b = cap_n; d = done_n; s = sent_n;
    push(8'hA5); push(8'h5A); push(8'hFF); push(8'h00);
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    wait_done_count(d + 7, 400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_first_timeout: done_n=%0d", done_n); end
    repeat (9) @(negedge clock);
    rx_byte(8'hA0);
    wait_done_count(d + 14, 400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_second_timeout: done_n=%0d", done_n); end
    repeat (4) @(negedge clock);
    rx_byte(8'hA0);
    repeat (4) @(negedge clock);
    vectors++;
    if (sent_n != s + 1) begin
      miscompares++; $display("FAIL b2b_wrong_ack: sent=%0d, want %0d", sent_n, s + 1);
    end
    rx_byte(8'hA1);
    repeat (5) @(negedge clock);
    vectors++;
    if (frame_at(b) !== 56'h7E_00_A5_5A_FF_00_00) begin
      miscompares++; $display("FAIL b2b_frame0: got %h, want 7e00a55aff0000", frame_at(b));
    end
    vectors++;
    if (frame_at(b + 7) !== 56'h7E_01_10_20_30_40_41) begin
      miscompares++; $display("FAIL b2b_frame1: got %h, want 7e011020304041", frame_at(b + 7));
    end
    vectors++;
    if (sent_n != s + 2 || cap_n != b + 14) begin
      miscompares++; $display("FAIL b2b_count: sent=%0d bytes=%0d, want %0d 14", sent_n, cap_n - b, s + 2);
    end
  endtask

  task automatic test_retry_exhaust;
    int b, s, f, n;
    b = cap_n; s = sent_n; f = fail_n;
    push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
    n = 0;
    while (fail_n == f && n < 3000) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (fail_n != f + 1) begin miscompares++; $display("FAIL retry_no_fail_pulse: fail=%0d, want %0d", fail_n, f + 1); end
    repeat (3) @(negedge clock);
    vectors++;
    if (cap_n != b + 28) begin miscompares++; $display("FAIL retry_bytes: got %0d, want 28", cap_n - b); end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (frame_at(b + 7 * k) !== 56'h7E_00_DE_AD_BE_EF_22) begin
        miscompares++; $display("FAIL retry_frame%0d: got %h, want 7e00deadbeef22", k, frame_at(b + 7 * k));
      end
    end
    vectors++;
    if ({cap_retry[b], cap_retry[b + 7], cap_retry[b + 14], cap_retry[b + 21]} !== 8'b00_01_10_11) begin
      miscompares++; $display("FAIL retry_counts: got %b, want 00011011",
        {cap_retry[b], cap_retry[b + 7], cap_retry[b + 14], cap_retry[b + 21]});
    end
    // pkt_failed is seen one edge after the timeout edge
    vectors++;
    if (fail_cyc - last_done_cyc != TIMEOUT + 1) begin
      miscompares++; $display("FAIL retry_fail_time: got %0d, want %0d", fail_cyc - last_done_cyc, TIMEOUT + 1);
    end
    vectors++;
    if (sent_n != s || retry_count !== 2'd0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL retry_final: sent=%0d retry=%0d busy=%b, want %0d 0 0", sent_n, retry_count, busy, s);
    end
  endtask

  task automatic test_fill_stall;
    int b, s;
    bit ok;
    b = cap_n; s = sent_n;
    push(8'h12); push(8'h34);
    repeat (40) @(negedge clock);
    vectors++;
    if (busy !== 1'b1 || cap_n != b || rdreq !== 1'b0) begin
      miscompares++; $display("FAIL stall_hold: busy=%b bytes=%0d rdreq=%b, want 1 0 0", busy, cap_n - b, rdreq);
    end
    rx_byte(8'hA0);
    push(8'h56); push(8'h78);
    wait_done_count(done_n + 7, 400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL stall_frame_timeout: done_n=%0d", done_n); end
    repeat (9) @(negedge clock);
    rx_byte(8'hA0);
    repeat (5) @(negedge clock);
    vectors++;
    if (frame_at(b) !== 56'h7E_00_12_34_56_78_08) begin
      miscompares++; $display("FAIL stall_frame: got %h, want 7e001234567808", frame_at(b));
    end
    vectors++;
    if (sent_n != s + 1 || cap_n != b + 7) begin
      miscompares++; $display("FAIL stall_count: sent=%0d bytes=%0d, want %0d 7", sent_n, cap_n - b, s + 1);
    end
  endtask

  task automatic test_reset_mid_frame;
    int b, s, n;
    bit ok;
    b = cap_n;
    push(8'h9A); push(8'hBC); push(8'hDE); push(8'hF0);
    n = 0;
    while (cap_n < b + 3 && n < 200) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (busy !== 1'b1 || data_transmit !== 8'h9A || cap[b + 1] !== 8'h01) begin
      miscompares++; $display("FAIL rst_pre: busy=%b tx=%h seq=%h, want 1 9a 01", busy, data_transmit, cap[b + 1]);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, data_ready, rdreq, pkt_sent, pkt_failed, retry_count, data_transmit} !== 15'h0) begin
      miscompares++; $display("FAIL rst_async: got %h, want 0",
        {busy, data_ready, rdreq, pkt_sent, pkt_failed, retry_count, data_transmit});
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_idle: busy=%b, want 0", busy); end
    b = cap_n; s = sent_n;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    wait_done_count(done_n + 7, 400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rst_frame_timeout: done_n=%0d", done_n); end
    repeat (9) @(negedge clock);
    rx_byte(8'hA0);
    repeat (5) @(negedge clock);
    vectors++;
    if (frame_at(b) !== 56'h7E_00_55_66_77_88_CC) begin
      miscompares++; $display("FAIL rst_frame: got %h, want 7e0055667788cc", frame_at(b));
    end
    vectors++;
    if (sent_n != s + 1) begin miscompares++; $display("FAIL rst_sent: got %0d, want %0d", sent_n, s + 1); end
  endtask

  initial begin
    reset      = 1'b1;
    en         = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    test_reset();
    test_single_packet();
    test_ack_on_timeout();
    test_back_to_back();
    test_retry_exhaust();
    test_fill_stall();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
